mstr_axi4_wr_burst_buffer: RTL and testbench

Write-channel burst buffer between the master AHB-Lite-to-AXI4 converter and the interconnect master port. It captures the converter's AW request and buffers the W beats. AW goes downstream only once a complete burst is resident, so a slow AHB master never stalls W inside the crossbar. It also caps outstanding write bursts and passes the B channel through.

---
 rtl/mstr_wr_buf_pkg.sv | 51 +++++
 rtl/mstr_axi4_wr_burst_buffer_if.sv | 39 +++
 rtl/mstr_wr_buf_fifo.sv | 49 ++++
 rtl/mstr_axi4_wr_burst_buffer.sv | 180 ++++++++++++++++++
 tb/tb_mstr_axi4_wr_burst_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mstr_wr_buf_pkg.sv
// mstr_wr_buf_pkg
// Shared definitions for the master write-channel burst buffer:
//   - AXI field widths and helper functions that compute the packed AW/W/B
//     payload widths and field offsets from the block parameters
//   - FSM state encoding
// AW packing (MSB..LSB): {ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,REGION,QOS,USER}
// W  packing (MSB..LSB): {DATA,STRB,LAST,USER}
// B  packing (MSB..LSB): {ID,RESP,USER}
package mstr_wr_buf_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 1;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int REGION_W = 4;
    localparam int QOS_W    = 4;
    localparam int RESP_W   = 2;

    function automatic int aw_pw(input int id_w, input int addr_w, input int user_w);
        return id_w + addr_w + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W
             + PROT_W + REGION_W + QOS_W + user_w;
    endfunction

    function automatic int w_pw(input int data_w, input int user_w);
        return data_w + data_w / 8 + 1 + user_w;
    endfunction

    function automatic int b_pw(input int id_w, input int user_w);
        return id_w + RESP_W + user_w;
    endfunction

    // LSB offset of LEN inside the AW payload
    function automatic int aw_len_ofs(input int user_w);
        return user_w + QOS_W + REGION_W + PROT_W + CACHE_W + LOCK_W + BURST_W + SIZE_W;
    endfunction

    // Bit offset of LAST inside the W payload
    function automatic int w_last_ofs(input int user_w);
        return user_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        DRAIN   = 2'd3
    } wr_state_e;

endpackage

// File: rtl/mstr_axi4_wr_burst_buffer_if.sv
// mstr_axi4_wr_burst_buffer_if
// One AXI4 write port (AW, W, B) carried as packed payloads plus handshakes.
//   master modport: drives AW/W and bready, receives B
//   slave  modport: receives AW/W, drives ready signals and B
interface mstr_axi4_wr_burst_buffer_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    import mstr_wr_buf_pkg::*;

    localparam int AW_PW = aw_pw(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int W_PW  = w_pw(DATA_WIDTH, USER_WIDTH);
    localparam int B_PW  = b_pw(ID_WIDTH, USER_WIDTH);

    logic [AW_PW-1:0] aw_payload;
    logic             awvalid;
    logic             awready;
    logic [W_PW-1:0]  w_payload;
    logic             wvalid;
    logic             wready;
    logic [B_PW-1:0]  b_payload;
    logic             bvalid;
    logic             bready;

    modport master (
        output aw_payload, awvalid, input awready,
        output w_payload,  wvalid,  input wready,
        input  b_payload,  bvalid,  output bready
    );

    modport slave (
        input  aw_payload, awvalid, output awready,
        input  w_payload,  wvalid,  output wready,
        output b_payload,  bvalid,  input bready
    );

endinterface

// File: rtl/mstr_wr_buf_fifo.sv
// mstr_wr_buf_fifo
// Synchronous first-word fall-through FIFO. The head entry is visible on dout
// while empty is low; a write becomes visible the cycle after it is taken.
// Ports: clk, rst (sync, active high), push/din, pop/dout, full, empty.
// Pushes while full and pops while empty are ignored.
module mstr_wr_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full from empty when the indexes match
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/mstr_axi4_wr_burst_buffer.sv
// mstr_axi4_wr_burst_buffer
// Write burst buffer between the AHB-to-AXI4 converter and the interconnect.
// AW is held until the whole burst sits in the W FIFO (or the burst cannot fit,
// in which case it cuts through), so W never stalls inside the crossbar.
// Outstanding write bursts are capped at MAX_OUTS; B passes straight through.
// Ports:
//   ACLK, sysReset (sync, active high)
//   up       : slave side, AW/W from the converter, B back to it
//   m        : master side, AW/W to the interconnect, B from it
//   last_err : sticky WLAST mismatch flag
// Optional feature: MSTR_WRBUF_LAST_CHECK_EN generates WLAST from a beat
// counter against the held LEN and flags disagreement with the stored LAST.
module mstr_axi4_wr_burst_buffer
    import mstr_wr_buf_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUTS   = 4
) (
    input  logic ACLK,
    input  logic sysReset,
    mstr_axi4_wr_burst_buffer_if.slave  up,
    mstr_axi4_wr_burst_buffer_if.master m,
    output logic last_err
);
    localparam int AW_PW    = aw_pw(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
    localparam int W_PW     = w_pw(DATA_WIDTH, USER_WIDTH);
    localparam int LEN_OFS  = aw_len_ofs(USER_WIDTH);
    localparam int LAST_OFS = w_last_ofs(USER_WIDTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int OUTS_W   = $clog2(MAX_OUTS + 1);
    localparam logic [31:0] DEPTH32 = FIFO_DEPTH;

    wr_state_e        state;
    logic [AW_PW-1:0] held_aw;
    logic [LEN_W-1:0] held_len;
    logic             aw_vld_q;
    logic [CNT_W-1:0] last_cnt;
    logic [OUTS_W-1:0] outs_cnt;

    logic [W_PW-1:0]  f_head;
    logic             f_full;
    logic             f_empty;
    logic             push;
    logic             pop;
    logic             head_last;
    logic             final_beat;
    logic             out_last;
    logic             m_wvalid;
    logic             up_aw_hs;
    logic             m_aw_hs;
    logic             m_b_hs;
    logic             cut_through;
    logic             can_issue;
    logic [W_PW-1:0]  w_out;

    // ---------------- handshakes ----------------
    assign up.awready = (state == IDLE) && !sysReset;
    assign up.wready  = !f_full && !sysReset;
    assign up_aw_hs   = up.awvalid && up.awready;
    assign push       = up.wvalid && up.wready;

    assign m.awvalid    = aw_vld_q;
    assign m.aw_payload = held_aw;
    assign m_aw_hs      = aw_vld_q && m.awready;

    assign m_wvalid  = (state == DRAIN) && !f_empty;
    assign m.wvalid  = m_wvalid;
    assign pop       = m_wvalid && m.wready;
    assign head_last = f_head[LAST_OFS];

    // B is a pure pass-through
    assign up.b_payload = m.b_payload;
    assign up.bvalid    = m.bvalid;
    assign m.bready     = up.bready;
    assign m_b_hs       = m.bvalid && up.bready;

    // A burst longer than the FIFO can never be fully resident; issue it early
    assign cut_through = ({{(32-LEN_W){1'b0}}, held_len} >= DEPTH32);
    assign can_issue   = ((last_cnt != '0) || cut_through) &&
                         (outs_cnt < OUTS_W'(MAX_OUTS));

    // ---------------- W FIFO ----------------
    mstr_wr_buf_fifo #(
        .WIDTH (W_PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (sysReset),
        .push  (push),
        .din   (up.w_payload),
        .pop   (pop),
        .dout  (f_head),
        .full  (f_full),
        .empty (f_empty)
    );

`ifdef MSTR_WRBUF_LAST_CHECK_EN
    logic [LEN_W-1:0] beat_cnt;
    logic             cnt_last;

    assign cnt_last   = (beat_cnt == held_len);
    assign final_beat = cnt_last;
    assign out_last   = cnt_last;

    // Counter restarts on the AW handshake, i.e. on entry to DRAIN
    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            beat_cnt <= '0;
            last_err <= 1'b0;
        end else begin
            if (m_aw_hs)  beat_cnt <= '0;
            else if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
            if (pop && (head_last != cnt_last)) last_err <= 1'b1;
        end
    end
`else
    assign final_beat = head_last;
    assign out_last   = head_last;
    assign last_err   = 1'b0;
`endif

    // LAST only ever asserted alongside a valid beat
    always_comb begin
        w_out           = f_head;
        w_out[LAST_OFS] = out_last && m_wvalid;
    end
    assign m.w_payload = w_out;

    // ---------------- counters ----------------
    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            last_cnt <= '0;
            outs_cnt <= '0;
        end else begin
            case ({push && up.w_payload[LAST_OFS], pop && head_last})
                2'b10:   last_cnt <= last_cnt + CNT_W'(1);
                2'b01:   last_cnt <= last_cnt - CNT_W'(1);
                default: last_cnt <= last_cnt;
            endcase
            case ({m_aw_hs, m_b_hs})
                2'b10:   outs_cnt <= outs_cnt + OUTS_W'(1);
                2'b01:   outs_cnt <= outs_cnt - OUTS_W'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            state    <= IDLE;
            aw_vld_q <= 1'b0;
            held_aw  <= '0;
            held_len <= '0;
        end else begin
            case (state)
                IDLE: if (up_aw_hs) begin
                    held_aw  <= up.aw_payload;
                    held_len <= up.aw_payload[LEN_OFS +: LEN_W];
                    state    <= COLLECT;
                end
                COLLECT: if (can_issue) begin
                    aw_vld_q <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: if (m.awready) begin
                    aw_vld_q <= 1'b0;
                    state    <= DRAIN;
                end
                DRAIN: if (pop && final_beat) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mstr_axi4_wr_burst_buffer.sv
module tb_mstr_axi4_wr_burst_buffer;
    import mstr_wr_buf_pkg::*;

    localparam int IDW   = 1;
    localparam int ADW   = 20;
    localparam int DW    = 32;
    localparam int UW    = 1;
    localparam int DEPTH = 16;
    localparam int MOUTS = 2;
    localparam int AWP   = aw_pw(IDW, ADW, UW);
    localparam int WP    = w_pw(DW, UW);

    logic ACLK = 1'b0;
    logic sysReset = 1'b1;
    logic last_err;

    always #5 ACLK = ~ACLK;

    mstr_axi4_wr_burst_buffer_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) up_if ();
    mstr_axi4_wr_burst_buffer_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    mstr_axi4_wr_burst_buffer #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .FIFO_DEPTH(DEPTH), .MAX_OUTS(MOUTS)
    ) dut (
        .ACLK     (ACLK),
        .sysReset (sysReset),
        .up       (up_if),
        .m        (m_if),
        .last_err (last_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [WP-1:0] beat_q [$];
    int            beat_cyc [$];

    always @(posedge ACLK) cyc <= cyc + 1;

    // Downstream W beats accepted at the coming edge
    always @(negedge ACLK)
        if (!sysReset && m_if.wvalid && m_if.wready) begin
            beat_q.push_back(m_if.w_payload);
            beat_cyc.push_back(cyc);
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AWP-1:0] mk_aw(input logic [7:0] len, input logic [19:0] addr);
        return {1'b1, addr, len, 3'd2, 2'd1, 1'b0, 4'h3, 3'd0, 4'd0, 4'd0, 1'b0};
    endfunction

    function automatic logic [WP-1:0] mk_w(input logic [31:0] d, input logic last);
        return {d, 4'hF, last, 1'b0};
    endfunction

    function automatic logic [31:0] wd(input logic [WP-1:0] p);
        return p[WP-1 -: 32];
    endfunction

    function automatic logic wl(input logic [WP-1:0] p);
        return p[1];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic rst_pulse();
        sysReset = 1'b1;
        tick();
        tick();
        sysReset = 1'b0;
    endtask

    task automatic b_hs();
        m_if.bvalid    = 1'b1;
        m_if.b_payload = 4'h5;
        up_if.bready   = 1'b1;
        tick();
        m_if.bvalid  = 1'b0;
        up_if.bready = 1'b0;
    endtask

    // Returns at the start of a cycle in which AW and W would both be taken
    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge ACLK);
        while (!(up_if.awready && up_if.wready) && n < 100) begin
            tick();
            @(negedge ACLK);
            n++;
        end
        chk(tag, 64'(n < 100), 64'd1);
        tick();
    endtask

    // Ends at the negedge of the cycle showing m_awvalid
    task automatic wait_awvalid(input string tag, input int lim);
        int n = 0;
        @(negedge ACLK);
        while (!m_if.awvalid && n < lim) begin
            tick();
            @(negedge ACLK);
            n++;
        end
        chk(tag, 64'(m_if.awvalid), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int k, input int lim);
        int n = 0;
        while (beat_q.size() < k && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 64'(beat_q.size()), 64'(k));
    endtask

    // AW with the first beat, then the remaining beats back to back
    task automatic send_burst(input logic [31:0] base, input int nb, input int last_idx);
        wait_ready("send_rdy");
        for (int i = 0; i < nb; i++) begin
            up_if.awvalid    = (i == 0);
            up_if.aw_payload = mk_aw(8'(nb - 1), 20'h2_0000);
            up_if.wvalid     = 1'b1;
            up_if.w_payload  = mk_w(base + 32'(i), i == last_idx);
            tick();
        end
        up_if.awvalid = 1'b0;
        up_if.wvalid  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        up_if.aw_payload = '0; up_if.awvalid = 1'b0;
        up_if.w_payload  = '0; up_if.wvalid  = 1'b0;
        up_if.bready     = 1'b0;
        m_if.awready     = 1'b1; m_if.wready = 1'b1;
        m_if.b_payload   = '0;   m_if.bvalid = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        @(negedge ACLK);
        chk("rst_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("rst_wvalid",  64'(m_if.wvalid),  64'd0);
        chk("rst_awready", 64'(up_if.awready), 64'd0);
        chk("rst_wready",  64'(up_if.wready), 64'd0);
        chk("rst_lasterr", 64'(last_err), 64'd0);
        tick();
        sysReset = 1'b0;
        @(negedge ACLK);
        chk("rel_awready", 64'(up_if.awready), 64'd1);
        chk("rel_wready",  64'(up_if.wready),  64'd1);
        tick();

        // ---- T1: single beat, AW+W same cycle N ----
        beat_q.delete(); beat_cyc.delete();
        up_if.awvalid = 1'b1; up_if.aw_payload = mk_aw(8'd0, 20'h0_1000);
        up_if.wvalid  = 1'b1; up_if.w_payload  = mk_w(32'hA5A5A5A5, 1'b1);
        @(negedge ACLK);
        chk("t1_awready", 64'(up_if.awready), 64'd1);
        tick();
        up_if.awvalid = 1'b0; up_if.wvalid = 1'b0;
        @(negedge ACLK);
        chk("t1_n1_awvalid", 64'(m_if.awvalid), 64'd0);
        tick();
        @(negedge ACLK);
        chk("t1_n2_awvalid", 64'(m_if.awvalid), 64'd1);
        chk("t1_aw_payload", 64'(m_if.aw_payload), 64'(mk_aw(8'd0, 20'h0_1000)));
        tick();
        @(negedge ACLK);
        chk("t1_wvalid", 64'(m_if.wvalid), 64'd1);
        chk("t1_wdata",  64'(wd(m_if.w_payload)), 64'hA5A5A5A5);
        chk("t1_wlast",  64'(wl(m_if.w_payload)), 64'd1);
        tick();
        @(negedge ACLK);
        chk("t1_idle_awready", 64'(up_if.awready), 64'd1);
        chk("t1_idle_wvalid",  64'(m_if.wvalid), 64'd0);
        chk("t1_nbeats", 64'(beat_q.size()), 64'd1);
        tick();
        m_if.bvalid = 1'b1; m_if.b_payload = 4'hA; up_if.bready = 1'b1;
        @(negedge ACLK);
        chk("t1_b_valid",   64'(up_if.bvalid), 64'd1);
        chk("t1_b_payload", 64'(up_if.b_payload), 64'hA);
        chk("t1_b_ready",   64'(m_if.bready), 64'd1);
        tick();
        m_if.bvalid = 1'b0; up_if.bready = 1'b0;

        // ---- T2: W ahead of AW ----
        beat_q.delete(); beat_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            up_if.wvalid = 1'b1; up_if.w_payload = mk_w(32'(i + 1), i == 3);
            tick();
        end
        up_if.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t2_no_awvalid", 64'(m_if.awvalid), 64'd0);
            tick();
        end
        up_if.awvalid = 1'b1; up_if.aw_payload = mk_aw(8'd3, 20'h0_2000);
        tick();
        up_if.awvalid = 1'b0;
        wait_awvalid("t2_awvalid", 10);
        tick();
        wait_beats("t2_nbeats", 4, 20);
        for (int i = 0; i < beat_q.size(); i++) begin
            chk("t2_data", 64'(wd(beat_q[i])), 64'(i + 1));
            chk("t2_last", 64'(wl(beat_q[i])), 64'(i == 3));
        end
        if (beat_q.size() == 4) chk("t2_consecutive", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
        b_hs();

        // ---- T3: backpressure mid-DRAIN ----
        beat_q.delete(); beat_cyc.delete();
        send_burst(32'h11, 4, 3);
        wait_awvalid("t3_awvalid", 10);
        tick();
        @(negedge ACLK);
        chk("t3_first", 64'(wd(m_if.w_payload)), 64'h11);
        tick();
        m_if.wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t3_hold_valid", 64'(m_if.wvalid), 64'd1);
            chk("t3_hold_data",  64'(wd(m_if.w_payload)), 64'h12);
            tick();
        end
        m_if.wready = 1'b1;
        wait_beats("t3_nbeats", 4, 20);
        repeat (3) tick();
        chk("t3_no_dup", 64'(beat_q.size()), 64'd4);
        for (int i = 0; i < beat_q.size(); i++)
            chk("t3_data", 64'(wd(beat_q[i])), 64'(32'h11 + 32'(i)));
        b_hs();

        // ---- T4: outstanding cap, MAX_OUTS=2 ----
        rst_pulse();
        beat_q.delete(); beat_cyc.delete();
        send_burst(32'h21, 1, 0);
        send_burst(32'h22, 1, 0);
        send_burst(32'h23, 1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            chk("t4_cap_block", 64'(m_if.awvalid), 64'd0);
            tick();
        end
        m_if.awready = 1'b0;
        m_if.bvalid = 1'b1; up_if.bready = 1'b1;
        @(negedge ACLK);
        chk("t4_b_cyc", 64'(m_if.awvalid), 64'd0);
        tick();
        m_if.bvalid = 1'b0; up_if.bready = 1'b0;
        @(negedge ACLK);
        chk("t4_b_plus1", 64'(m_if.awvalid), 64'd0);
        tick();
        @(negedge ACLK);
        chk("t4_b_plus2", 64'(m_if.awvalid), 64'd1);
        tick();
        // AW issue and B in the same cycle: count must stay put
        m_if.awready = 1'b1; m_if.bvalid = 1'b1; up_if.bready = 1'b1;
        @(negedge ACLK);
        chk("t4_simul_aw", 64'(m_if.awvalid), 64'd1);
        tick();
        m_if.bvalid = 1'b0; up_if.bready = 1'b0;
        send_burst(32'h24, 1, 0);
        wait_awvalid("t4_4th_issues", 10);
        tick();
        send_burst(32'h25, 1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            chk("t4_5th_block", 64'(m_if.awvalid), 64'd0);
            tick();
        end
        b_hs();
        wait_awvalid("t4_5th_issues", 10);
        tick();
        wait_beats("t4_nbeats", 5, 30);
        for (int i = 0; i < beat_q.size(); i++)
            chk("t4_data", 64'(wd(beat_q[i])), 64'(32'h21 + 32'(i)));

        // ---- T5: cut-through, LEN=31 ----
        rst_pulse();
        beat_q.delete(); beat_cyc.delete();
        m_if.wready = 1'b0;
        wait_ready("t5_rdy");
        up_if.awvalid = 1'b1; up_if.aw_payload = mk_aw(8'd31, 20'h0_3000);
        tick();
        up_if.awvalid = 1'b0;
        @(negedge ACLK);
        chk("t5_collect", 64'(m_if.awvalid), 64'd0);
        tick();
        @(negedge ACLK);
        chk("t5_issue_nolast", 64'(m_if.awvalid), 64'd1);
        tick();
        begin
            int i = 0;
            int n = 0;
            logic saw_full = 1'b0;
            while (i < 32 && n < 400) begin
                up_if.wvalid = 1'b1;
                up_if.w_payload = mk_w(32'h100 + 32'(i), i == 31);
                @(negedge ACLK);
                if (up_if.wready) i++;
                else saw_full = 1'b1;
                tick();
                n++;
                if (n == 25) m_if.wready = 1'b1;
            end
            up_if.wvalid = 1'b0;
            chk("t5_pushed", 64'(i), 64'd32);
            chk("t5_throttled", 64'(saw_full), 64'd1);
        end
        wait_beats("t5_nbeats", 32, 100);
        for (int i = 0; i < beat_q.size(); i++) begin
            chk("t5_data", 64'(wd(beat_q[i])), 64'(32'h100 + 32'(i)));
            chk("t5_last", 64'(wl(beat_q[i])), 64'(i == 31));
        end
        tick();
        @(negedge ACLK);
        chk("t5_idle", 64'(up_if.awready), 64'd1);
        tick();

`ifdef MSTR_WRBUF_LAST_CHECK_EN
        // ---- T6: early upstream LAST, counter-generated WLAST ----
        beat_q.delete(); beat_cyc.delete();
        send_burst(32'h31, 4, 1);
        wait_beats("t6_nbeats", 4, 40);
        for (int i = 0; i < beat_q.size(); i++)
            chk("t6_wlast", 64'(wl(beat_q[i])), 64'(i == 3));
        tick();
        chk("t6_last_err", 64'(last_err), 64'd1);
        rst_pulse();
`endif

        // ---- T7: reset mid-DRAIN ----
        beat_q.delete(); beat_cyc.delete();
        m_if.wready = 1'b0;
        send_burst(32'h41, 4, 3);
        wait_awvalid("t7_awvalid", 10);
        tick();
        @(negedge ACLK);
        chk("t7_drain_valid", 64'(m_if.wvalid), 64'd1);
        tick();
        sysReset = 1'b1;
        tick();
        sysReset = 1'b0;
        @(negedge ACLK);
        chk("t7_wvalid",  64'(m_if.wvalid), 64'd0);
        chk("t7_awready", 64'(up_if.awready), 64'd1);
        chk("t7_wready",  64'(up_if.wready), 64'd1);
        chk("t7_lasterr", 64'(last_err), 64'd0);
        tick();
        m_if.wready = 1'b1;
        send_burst(32'h55, 1, 0);
        wait_beats("t7_nbeats", 1, 20);
        if (beat_q.size() > 0) chk("t7_fifo_flushed", 64'(wd(beat_q[0])), 64'h55);
        repeat (3) tick();
        chk("t7_single", 64'(beat_q.size()), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
